seat_request_issuer: RTL and testbench

Initiator-side front end for the school seating system. Buffers seat requests (reserve / step-out / release) and configuration updates (ban, limit time) from a kiosk or host, and drives them onto the seating system's write interface. Seat requests are issued as single-cycle `write` pulses; configuration updates are issued as single-cycle `write_set` pulses, with a guaranteed idle gap after each pulse. It sits directly in front of `SchoolSeatingSystem` and owns every one of that block's request inputs.

---
 rtl/seat_request_issuer.sv | 114 +++++++++++
 tb/tb_seat_request_issuer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seat_request_issuer.sv
// seat_request_issuer: buffers seat requests and config updates, issues them as spaced write/write_set pulses
// Ports: clk, rst_n (async active-low); req_* seat request handshake into a DEPTH-entry FIFO;
// cfg_* single-entry configuration slot; Student_No/Seat_No/Seat_State + write seat strobe;
// write_set config strobe; ban/limit_time held config; pending FIFO occupancy; req_err reject pulse.
// Optional: define SEAT_REQ_VALIDATE_EN to drop out-of-range requests and pulse req_err.
module seat_request_issuer #(
  parameter int DEPTH = 4,
  parameter int GAP = 1,
  parameter int MAX_SEAT = 31,
  parameter logic [1:0] BAN_RST = 2'd2,
  parameter logic [10:0] LIMIT_RST = 11'd5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic [31:0] req_student,
  input  logic [4:0] req_seat,
  input  logic [1:0] req_state,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [1:0] cfg_sel,
  input  logic [1:0] cfg_ban,
  input  logic [10:0] cfg_limit,
  output logic [31:0] Student_No,
  output logic [4:0] Seat_No,
  output logic [1:0] Seat_State,
  output logic write,
  output logic [1:0] write_set,
  output logic [10:0] limit_time,
  output logic [1:0] ban,
  output logic [$clog2(DEPTH):0] pending,
  output logic req_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SEAT, CFG, WAIT} state_t;
  state_t state;
  logic [38:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic cfg_full;
  logic [1:0] slot_sel, slot_ban;
  logic [10:0] slot_limit;
  logic [3:0] cnt;
  logic accept, bad, push, pop, take, dispatch;
  assign accept = req_valid && req_ready;
`ifdef SEAT_REQ_VALIDATE_EN
  localparam logic [5:0] MAX = 6'(MAX_SEAT);
  assign bad = req_seat == 5'd0 || {1'b0, req_seat} > MAX || req_state == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) req_err <= 1'b0;
    else req_err <= accept && bad;
`else
  assign bad = 1'b0;
  assign req_err = 1'b0;
`endif
  assign push = accept && !bad;
  // the end of the idle gap dispatches directly so pulses can be GAP+1 cycles apart
  assign dispatch = state == IDLE || (state == WAIT && cnt == 4'd0);
  assign take = dispatch && cfg_full;
  assign pop = dispatch && !cfg_full && count != '0;
  assign req_ready = count != (AW+1)'(DEPTH);
  assign cfg_ready = !cfg_full;
  assign pending = count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_student, req_seat, req_state};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (push ? 1'b1 : 1'b0) - (pop ? 1'b1 : 1'b0);
    end
  // invalid selectors are handshaken but never occupy the slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_full <= 1'b0;
      slot_sel <= 2'd0;
      slot_ban <= 2'd0;
      slot_limit <= 11'd0;
    end else if (cfg_valid && !cfg_full && (cfg_sel == 2'd1 || cfg_sel == 2'd2)) begin
      cfg_full <= 1'b1;
      slot_sel <= cfg_sel;
      slot_ban <= cfg_ban;
      slot_limit <= cfg_limit;
    end else if (take) cfg_full <= 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      write <= 1'b0;
      write_set <= 2'd0;
      Student_No <= 32'd0;
      Seat_No <= 5'd0;
      Seat_State <= 2'd0;
      ban <= BAN_RST;
      limit_time <= LIMIT_RST;
    end else begin
      write <= pop;
      write_set <= take ? slot_sel : 2'd0;
      if (pop) {Student_No, Seat_No, Seat_State} <= mem[rd_ptr];
      if (take && slot_sel == 2'd1) ban <= slot_ban;
      if (take && slot_sel == 2'd2) limit_time <= slot_limit;
      if (dispatch) state <= take ? CFG : pop ? SEAT : IDLE;
      else if (state == WAIT) cnt <= cnt - 4'd1;
      else begin
        state <= GAP == 0 ? IDLE : WAIT;
        cnt <= 4'(GAP - 1);
      end
    end
endmodule

// File: tb/tb_seat_request_issuer.sv
// tb_seat_request_issuer: scoreboard bench for seat_request_issuer
module tb_seat_request_issuer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, cfg_valid = 1'b0;
  logic [31:0] req_student = '0;
  logic [4:0] req_seat = '0;
  logic [1:0] req_state = '0, cfg_sel = '0, cfg_ban = '0;
  logic [10:0] cfg_limit = '0;
  logic req_ready, cfg_ready, write, req_err;
  logic [31:0] Student_No;
  logic [4:0] Seat_No;
  logic [1:0] Seat_State, write_set, ban;
  logic [10:0] limit_time;
  logic [2:0] pending;
  always #5 clk = ~clk;
  seat_request_issuer #(.DEPTH(4), .GAP(1), .MAX_SEAT(31), .BAN_RST(2'd2), .LIMIT_RST(11'd5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_student(req_student), .req_seat(req_seat), .req_state(req_state),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_ban(cfg_ban),
    .cfg_limit(cfg_limit), .Student_No(Student_No), .Seat_No(Seat_No), .Seat_State(Seat_State),
    .write(write), .write_set(write_set), .limit_time(limit_time), .ban(ban),
    .pending(pending), .req_err(req_err));
  typedef struct {bit is_cfg; logic [38:0] seat; logic [14:0] cfgv; int gap;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, last = -100, errs = 0;
  bit stalled;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask
  function automatic exp_t s(logic [31:0] stu, logic [4:0] se, logic [1:0] st, int gap);
    exp_t e;
    e.is_cfg = 1'b0; e.seat = {stu, se, st}; e.cfgv = '0; e.gap = gap;
    return e;
  endfunction
  function automatic exp_t c(logic [1:0] sel, logic [1:0] b, logic [10:0] lim);
    exp_t e;
    e.is_cfg = 1'b1; e.seat = '0; e.cfgv = {sel, b, lim}; e.gap = 0;
    return e;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n) begin
    if (req_err) errs++;
    if (write || write_set != 2'd0) begin
      check("exclusive", 64'(write & (write_set != 2'd0)), 64'd0);
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: got write=%0d write_set=%0d expected none", write, write_set);
      end else begin
        automatic exp_t e = q.pop_front();
        check("kind", 64'(write_set != 2'd0), 64'(e.is_cfg));
        if (e.is_cfg) check("cfg_pulse", {write_set, ban, limit_time}, e.cfgv);
        else check("seat_fields", {Student_No, Seat_No, Seat_State}, e.seat);
        if (e.gap != 0) check("spacing", 64'(cyc - last), 64'(e.gap));
      end
      last = cyc;
    end
  end
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_req(logic [31:0] stu, logic [4:0] se, logic [1:0] st);
    int n = 0;
    req_valid = 1'b1; req_student = stu; req_seat = se; req_state = st;
    while (!req_ready && n < 50) begin stalled = 1'b1; @(posedge clk); #1; n++; end
    if (n == 50) begin tests++; fails++; $display("FAIL push_timeout: got req_ready=0 expected 1"); end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic send_cfg(logic [1:0] sel, logic [1:0] b, logic [10:0] lim);
    int n = 0;
    cfg_valid = 1'b1; cfg_sel = sel; cfg_ban = b; cfg_limit = lim;
    while (!cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin tests++; fails++; $display("FAIL cfg_timeout: got cfg_ready=0 expected 1"); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask
  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(10);
    check("rst_ban", ban, 2);
    check("rst_limit", limit_time, 5);
    check("rst_write", write, 0);
    check("rst_write_set", write_set, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_req_err", req_err, 0);
    q.push_back(s(32'd201819186, 5'd1, 2'd2, 0));
    push_req(32'd201819186, 5'd1, 2'd2);
    check("single_pending_k", pending, 1);
    check("single_write_k", write, 0);
    idle(1);
    check("single_write_k1", write, 1);
    check("single_pending_k1", pending, 0);
    idle(1);
    check("single_write_k2", write, 0);
    idle(5);
    stalled = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back(s(32'(1000 + i), 5'(i + 1), 2'(i % 3), i == 0 ? 0 : 2));
    for (int i = 0; i < 8; i++) push_req(32'(1000 + i), 5'(i + 1), 2'(i % 3));
    check("fill_stalled", 64'(stalled), 1);
    idle(20);
    check("fill_pending", pending, 0);
    q.push_back(s(32'd2001, 5'd3, 2'd2, 0));
    q.push_back(c(2'd1, 2'd0, 11'd5));
    q.push_back(s(32'd2002, 5'd4, 2'd1, 0));
    push_req(32'd2001, 5'd3, 2'd2);
    push_req(32'd2002, 5'd4, 2'd1);
    send_cfg(2'd1, 2'd0, 11'd0);
    idle(10);
    check("prio_ban", ban, 0);
    check("prio_limit", limit_time, 5);
    q.push_back(c(2'd2, 2'd0, 11'd300));
    send_cfg(2'd2, 2'd3, 11'd300);
    idle(6);
    check("limit_val", limit_time, 300);
    check("limit_ban", ban, 0);
    send_cfg(2'd3, 2'd1, 11'd77);
    idle(6);
    check("sel3_ban", ban, 0);
    check("sel3_limit", limit_time, 300);
    check("sel3_cfg_ready", cfg_ready, 1);
`ifdef SEAT_REQ_VALIDATE_EN
    errs = 0;
    push_req(32'd55, 5'd0, 2'd2);
    push_req(32'd56, 5'd5, 2'd3);
    idle(6);
    check("val_errs", 64'(errs), 2);
    check("val_pending", pending, 0);
`endif
    q.push_back(s(32'd3001, 5'd1, 2'd2, 0));
    for (int i = 0; i < 4; i++) push_req(32'(3001 + i), 5'(i + 1), 2'd2);
    check("mid_write_high", write, 1);
    rst_n = 1'b0;
    #1;
    check("rst_write_async", write, 0);
    check("rst_pending_async", pending, 0);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check("post_rst_pending", pending, 0);
    check("post_rst_ban", ban, 2);
    check("post_rst_limit", limit_time, 5);
    check("queue_drained", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
